voice_packetizer: RTL and testbench
===================================

Name: voice_packetizer

Overview:
Multi-channel successor to the single-call transport send path. It buffers 16-bit audio samples from NUM_CH independent call channels, one FIFO per channel. When a channel holds PKT_LEN samples, the block frames them into a packet of one header word (command, length, destination phone number) followed by the payload. A round-robin arbiter serialises the packets onto one valid/ready stream that feeds the transport layer.

Parameters:
DATA_W, 16, sample and packet word width
PHONE_W, 8, destination phone-number width
NUM_CH, 2, number of call channels (at least 1)
DEPTH, 16, per-channel FIFO depth in samples, power of 2
PKT_LEN, 8, samples per packet; must satisfy 1 ≤ PKT_LEN ≤ DEPTH and PKT_LEN < 2^(DATA_W-2-PHONE_W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
samp_in  in  NUM_CH*DATA_W  per-channel audio sample; channel i occupies bits [i*DATA_W +: DATA_W]
samp_valid  in  NUM_CH  per-channel sample write strobe
dest_phone  in  NUM_CH*PHONE_W  per-channel destination phone number
cmd_in  in  NUM_CH*2  per-channel 2-bit transport command
ovf_clr  in  NUM_CH  per-channel pulse that clears ovf
pkt_data  out  DATA_W  packet word
pkt_valid  out  1  pkt_data is valid
pkt_ready  in  1  downstream accepts the word
pkt_sof  out  1  current word is the header
pkt_eof  out  1  current word is the last word of the packet
pkt_chan  out  max(1,$clog2(NUM_CH))  source channel of the current packet
busy  out  1  a packet is in progress
ovf  out  NUM_CH  sticky per-channel overflow flag

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0, FIFOs empty, arbiter pointer 0, FSM in IDLE.
  - A packet in progress is abandoned; no eof is emitted for it.
- Write path:
  - A sample is written when samp_valid[i]=1.
  - If FIFO i is full in that cycle, the sample is dropped and ovf[i] is set, even if the FIFO is popped in the same cycle.
  - A write and a pop of the same FIFO in one cycle are both honoured; the count is unchanged.
- ovf[i] stays set until ovf_clr[i]=1 or reset. If a set condition and ovf_clr[i] occur in the same cycle, set wins.
- Header word layout:
  - Bits [DATA_W-1 -: 2] = cmd.
  - The middle field = PKT_LEN, zero-extended.
  - Bits [PHONE_W-1:0] = dest_phone.
  - Default layout is {cmd, 6'd len, 8'd phone}.
  - cmd and dest_phone of the granted channel are captured on the IDLE→HDR edge and held for the whole packet.
- FSM states: IDLE, HDR, PAYLOAD (plus CSUM when the optional feature is compiled in).
  - IDLE: the registered FIFO counts are evaluated. If any count is ≥ PKT_LEN, the FSM grants the first eligible channel at or after the round-robin pointer and moves to HDR.
  - HDR: pkt_valid=1, pkt_sof=1. On pkt_valid & pkt_ready, move to PAYLOAD.
  - PAYLOAD: presents PKT_LEN words, popping the granted FIFO on each accepted word. pkt_eof=1 on the last word. After the last word is accepted, the pointer becomes granted+1 (mod NUM_CH) and the FSM returns to IDLE.
- Timing:
  - The header is valid 2 edges after the edge that writes the PKT_LEN-th sample.
  - With pkt_ready held at 1, the packet streams with no gaps.
  - There is one idle cycle between packets.
- Backpressure: while pkt_valid=1 and pkt_ready=0, pkt_data, pkt_sof, pkt_eof and pkt_chan hold stable and pkt_valid does not drop.
- busy=1 in every state except IDLE. pkt_chan is valid while busy=1.

Optional Feature:
VOICE_PKT_CHECKSUM_EN
- Defined: a CSUM state follows PAYLOAD and appends one trailer word equal to the XOR of the header and all payload words.
  - pkt_eof moves from the last payload word to the trailer.
  - Packet length becomes PKT_LEN+2 words; the header length field still carries PKT_LEN.
- Undefined: no trailer; packets are PKT_LEN+1 words.

Decomposition:
- Shared package (telephony_pkg):
  - FSM state encoding.
  - Command constants: CMD_DATA=2'b00, CMD_DIAL=2'b01, CMD_HANG=2'b10, CMD_ACK=2'b11.
  - Header field offset and width localparams derived from DATA_W and PHONE_W.
- Sub-module: sample_fifo (DATA_W, DEPTH), instantiated NUM_CH times.
  - Synchronous-read register file.
  - Exposes count, full and empty.
  - Uses the same asynchronous active-high reset.

Test Plan:
- NUM_CH=2, PKT_LEN=4, DEPTH=8, pkt_ready=1; ch0 writes 0001..0004 with dest_phone=8'h17, cmd=2'b01 -> words 4417 (sof), 0001, 0002, 0003, 0004 (eof); pkt_chan=0; busy high for exactly 5 cycles.
- Both channels reach 4 samples on the same edge -> ch0 packet, one idle cycle, then ch1 packet. After refilling both -> ch0 served first again (pointer wrapped to 0).
- pkt_ready=0 for 3 cycles while payload word 0002 is presented -> 0002 held stable, pkt_valid held at 1; remaining words intact, nothing lost.
- ch1 writes 9 samples (0001..0009) with pkt_ready=0 -> ovf[1]=1, 0009 dropped; the two packets carry 0001..0004 and 0005..0008. Pulse ovf_clr[1] -> ovf[1]=0.
- Reset asserted mid-PAYLOAD -> pkt_valid, busy and ovf go to 0 immediately; a fresh 4-sample fill produces a correct packet starting with sof.
- VOICE_PKT_CHECKSUM_EN defined, stimulus of the first scenario -> trailer 16'h4413 with eof; 0004 no longer carries eof.

Source files
------------

// File: rtl/telephony_pkg.sv
// Shared telephony definitions: packetizer FSM encoding, transport commands
// and header field geometry helpers.
package telephony_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CSUM    = 2'd3;

  localparam logic [1:0] CMD_DATA = 2'b00;
  localparam logic [1:0] CMD_DIAL = 2'b01;
  localparam logic [1:0] CMD_HANG = 2'b10;
  localparam logic [1:0] CMD_ACK  = 2'b11;

  localparam int HDR_CMD_W = 2;

  // Header is {cmd, len, phone}; len fills whatever the other two leave free.
  function automatic int hdr_len_w(input int data_w, input int phone_w);
    return data_w - HDR_CMD_W - phone_w;
  endfunction

  function automatic int hdr_len_lsb(input int phone_w);
    return phone_w;
  endfunction

  function automatic int hdr_cmd_lsb(input int data_w);
    return data_w - HDR_CMD_W;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Per-channel sample FIFO: register file with a registered head word that is
// valid one cycle after it is written, so the reader sees the head without a read request.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_ok, rd_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    // A word landing in the slot that becomes the head must bypass the array.
    if (wr_ok && (wr_ptr_q == rd_ptr_d)) rd_data_d = wr_data;
    else                                 rd_data_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/voice_packetizer.sv
// Multi-channel voice packetizer: per-channel FIFOs, round-robin framing into {hdr, payload[, xor trailer]}.
// Header 2 edges after the filling write; words hold under pkt_ready=0; VOICE_PKT_CHECKSUM_EN adds the trailer.
module voice_packetizer
  import telephony_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PHONE_W = 8,
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 16,
  parameter int PKT_LEN = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CH*DATA_W-1:0]                 samp_in,
  input  logic [NUM_CH-1:0]                        samp_valid,
  input  logic [NUM_CH*PHONE_W-1:0]                dest_phone,
  input  logic [NUM_CH*2-1:0]                      cmd_in,
  input  logic [NUM_CH-1:0]                        ovf_clr,
  output logic [DATA_W-1:0]                        pkt_data,
  output logic                                     pkt_valid,
  input  logic                                     pkt_ready,
  output logic                                     pkt_sof,
  output logic                                     pkt_eof,
  output logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0] pkt_chan,
  output logic                                     busy,
  output logic [NUM_CH-1:0]                        ovf
);

  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNTW    = $clog2(DEPTH) + 1;
  localparam int BW      = $clog2(PKT_LEN + 1);
  localparam int LEN_W   = hdr_len_w(DATA_W, PHONE_W);
  localparam int LEN_LSB = hdr_len_lsb(PHONE_W);
  localparam int CMD_LSB = hdr_cmd_lsb(DATA_W);

  logic [1:0]                     state_q, state_d;
  logic [CW-1:0]                  grant_q, grant_d, ptr_q, ptr_d, pick, ptr_next;
  logic [1:0]                     cmd_q, cmd_d;
  logic [PHONE_W-1:0]             phone_q, phone_d;
  logic [BW-1:0]                  beat_q, beat_d;
  logic [NUM_CH-1:0]              elig_q, elig_d, ovf_q, ovf_d;
  logic [NUM_CH-1:0]              pop, fifo_full, fifo_empty;
  logic [NUM_CH-1:0][DATA_W-1:0]  fifo_dout;
  logic [NUM_CH-1:0][CNTW-1:0]    fifo_cnt;
  logic [DATA_W-1:0]              hdr_word, head_word;
  logic                           found, last_beat;
  int                             idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (samp_valid[i]),
      .wr_data (samp_in[i*DATA_W +: DATA_W]),
      .rd_en   (pop[i]),
      .rd_data (fifo_dout[i]),
      .count   (fifo_cnt[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );
  end

  assign head_word = fifo_dout[grant_q];
  assign last_beat = (beat_q == BW'(PKT_LEN - 1));
  assign ptr_next  = (grant_q == CW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    hdr_word = '0;
    hdr_word[CMD_LSB +: 2]       = cmd_q;
    hdr_word[LEN_LSB +: LEN_W]   = LEN_W'(PKT_LEN);
    hdr_word[PHONE_W-1:0]        = phone_q;
  end

  // Eligibility excludes this cycle's pop so the idle cycle after a packet never sees a stale count.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i]    = (state_q == ST_PAYLOAD) && pkt_ready && (grant_q == CW'(i)) && !fifo_empty[i];
      elig_d[i] = (fifo_cnt[i] - CNTW'(pop[i])) >= CNTW'(PKT_LEN);
      ovf_d[i]  = (samp_valid[i] && fifo_full[i]) || (ovf_q[i] && !ovf_clr[i]);
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr_q) + k) % NUM_CH;
      if (!found && elig_q[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    phone_d = phone_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: if (found) begin
        state_d = ST_HDR;
        grant_d = pick;
        cmd_d   = cmd_in[pick*2 +: 2];
        phone_d = dest_phone[pick*PHONE_W +: PHONE_W];
        beat_d  = '0;
      end
      ST_HDR: if (pkt_ready) state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (pkt_ready) begin
        if (last_beat) begin
`ifdef VOICE_PKT_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_IDLE;
          ptr_d   = ptr_next;
`endif
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
`ifdef VOICE_PKT_CHECKSUM_EN
      ST_CSUM: if (pkt_ready) begin
        state_d = ST_IDLE;
        ptr_d   = ptr_next;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef VOICE_PKT_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (pkt_ready && (state_q == ST_HDR))          csum_d = hdr_word;
    else if (pkt_ready && (state_q == ST_PAYLOAD)) csum_d = csum_q ^ head_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign pkt_eof = (state_q == ST_CSUM);
`else
  assign pkt_eof = (state_q == ST_PAYLOAD) && last_beat;
`endif

  always_comb begin
    pkt_data = '0;
    case (state_q)
      ST_HDR:     pkt_data = hdr_word;
      ST_PAYLOAD: pkt_data = head_word;
`ifdef VOICE_PKT_CHECKSUM_EN
      ST_CSUM:    pkt_data = csum_q;
`endif
      default:    pkt_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cmd_q   <= '0;
      phone_q <= '0;
      beat_q  <= '0;
      elig_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      phone_q <= phone_d;
      beat_q  <= beat_d;
      elig_q  <= elig_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pkt_valid = (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign pkt_sof   = (state_q == ST_HDR);
  assign pkt_chan  = grant_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_voice_packetizer.sv
// Scoreboard bench for voice_packetizer (2 channels, 4-sample packets, depth 8).
module tb_voice_packetizer;
  import telephony_pkg::*;

  localparam int NUM_CH = 2, DATA_W = 16, PHONE_W = 8, DEPTH = 8, PKT_LEN = 4;
`ifdef VOICE_PKT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic                       clk, reset;
  logic [NUM_CH*DATA_W-1:0]   samp_in;
  logic [NUM_CH-1:0]          samp_valid, ovf_clr, ovf;
  logic [NUM_CH*PHONE_W-1:0]  dest_phone;
  logic [NUM_CH*2-1:0]        cmd_in;
  logic [DATA_W-1:0]          pkt_data;
  logic                       pkt_valid, pkt_ready, pkt_sof, pkt_eof, busy;
  logic [0:0]                 pkt_chan;

  voice_packetizer #(.DATA_W(DATA_W), .PHONE_W(PHONE_W), .NUM_CH(NUM_CH),
                     .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .reset(reset), .samp_in(samp_in), .samp_valid(samp_valid),
    .dest_phone(dest_phone), .cmd_in(cmd_in), .ovf_clr(ovf_clr),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_sof(pkt_sof), .pkt_eof(pkt_eof), .pkt_chan(pkt_chan),
    .busy(busy), .ovf(ovf)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eof;
    logic        chan;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Monitor: every accepted word is compared against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && pkt_valid && pkt_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_word: got %h sof=%b eof=%b chan=%0d, required no word",
                 pkt_data, pkt_sof, pkt_eof, pkt_chan);
      end else begin
        e = exp_q.pop_front();
        check("pkt_word{data,sof,eof,chan}", {13'b0, pkt_data, pkt_sof, pkt_eof, pkt_chan}, {13'b0, e});
      end
    end
  end

  function automatic logic [15:0] hdr(input logic [1:0] cmd, input logic [7:0] ph);
    return {cmd, 6'd4, ph};
  endfunction

  task automatic push_pkt(input logic ch, input logic [1:0] cmd, input logic [7:0] ph,
                          input logic [15:0] first);
    logic [15:0] x, w;
    x = hdr(cmd, ph);
    exp_q.push_back('{x, 1'b1, 1'b0, ch});
    for (int k = 0; k < PKT_LEN; k++) begin
      w = first + 16'(k);
      x = x ^ w;
      exp_q.push_back('{w, 1'b0, (k == PKT_LEN-1) && !CSUM_EN, ch});
    end
    if (CSUM_EN) exp_q.push_back('{x, 1'b0, 1'b1, ch});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ch(input int ch, input logic [15:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      samp_in[ch*16 +: 16] = first + 16'(k);
      samp_valid = '0;
      samp_valid[ch] = 1'b1;
      tick();
    end
    samp_valid = '0;
  endtask

  task automatic write_both(input logic [15:0] f0, input logic [15:0] f1, input int n);
    for (int k = 0; k < n; k++) begin
      samp_in = {f1 + 16'(k), f0 + 16'(k)};
      samp_valid = 2'b11;
      tick();
    end
    samp_valid = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 300 && (exp_q.size() != 0 || busy); c++) tick();
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    bit hit;
    reset = 1'b1;
    samp_in = '0; samp_valid = '0; ovf_clr = '0; pkt_ready = 1'b1;
    dest_phone = {8'h2A, 8'h17};
    cmd_in = {CMD_HANG, CMD_DIAL};
    #1;
    check("rst_outputs{valid,sof,eof,busy,ovf}", {pkt_valid, pkt_sof, pkt_eof, busy, ovf}, 0);
    check("rst_data", pkt_data, 0);
    tick();
    reset = 1'b0;

    // 1: single packet, latency and busy length
    push_pkt(1'b0, CMD_DIAL, 8'h17, 16'h0001);
    write_ch(0, 16'h0001, 4);
    check("hdr_latency_edge0", pkt_valid, 0);
    tick();
    check("hdr_latency_edge1", pkt_valid, 0);
    tick();
    check("hdr_latency_edge2{valid,sof}", {pkt_valid, pkt_sof}, 2'b11);
    cnt = busy ? 1 : 0;
    for (int c = 0; c < 50 && busy; c++) begin
      tick();
      if (busy) cnt++;
    end
    check("busy_cycles", cnt, 5 + int'(CSUM_EN));
    wait_drain("drain_single");

    // 2: simultaneous fill, round robin, one idle cycle, pointer wrap
    pulse_reset();
    push_pkt(1'b0, CMD_DIAL, 8'h17, 16'h0011);
    push_pkt(1'b1, CMD_HANG, 8'h2A, 16'h0021);
    write_both(16'h0011, 16'h0021, 4);
    for (int c = 0; c < 20 && !busy; c++) tick();
    for (int c = 0; c < 40 && busy; c++) tick();
    cnt = 0;
    for (int c = 0; c < 20 && !busy; c++) begin
      cnt++;
      tick();
    end
    check("idle_gap", cnt, 1);
    wait_drain("drain_rr");
    push_pkt(1'b0, CMD_DIAL, 8'h17, 16'h0061);
    push_pkt(1'b1, CMD_HANG, 8'h2A, 16'h0071);
    write_both(16'h0061, 16'h0071, 4);
    wait_drain("drain_rr_wrap");

    // 3: backpressure on payload word 0032
    push_pkt(1'b0, CMD_DIAL, 8'h17, 16'h0031);
    write_ch(0, 16'h0031, 4);
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (pkt_valid && !pkt_sof && pkt_data == 16'h0032) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    check("bp_word_seen", hit, 1);
    pkt_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold{valid,sof,eof,data}", {pkt_valid, pkt_sof, pkt_eof, pkt_data}, {3'b100, 16'h0032});
    end
    pkt_ready = 1'b1;
    wait_drain("drain_bp");

    // 4: overflow on ch1, set-wins, clear, re-set
    pkt_ready = 1'b0;
    push_pkt(1'b1, CMD_HANG, 8'h2A, 16'h0001);
    push_pkt(1'b1, CMD_HANG, 8'h2A, 16'h0005);
    write_ch(1, 16'h0001, 9);
    check("ovf_set", ovf, 2'b10);
    samp_in[31:16] = 16'h00EE;
    samp_valid = 2'b10;
    ovf_clr = 2'b10;
    tick();
    samp_valid = '0;
    ovf_clr = '0;
    check("ovf_set_wins", ovf, 2'b10);
    ovf_clr = 2'b10;
    tick();
    ovf_clr = '0;
    check("ovf_clr", ovf, 2'b00);
    write_ch(1, 16'h00EF, 1);
    check("ovf_reset_again", ovf, 2'b10);
    pkt_ready = 1'b1;
    wait_drain("drain_ovf");
    check("ovf_sticky", ovf, 2'b10);

    // 5: reset in the middle of the payload
    exp_q.push_back('{hdr(CMD_DIAL, 8'h17), 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{16'h0041, 1'b0, 1'b0, 1'b0});
    write_ch(0, 16'h0041, 4);
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (pkt_valid && !pkt_sof && pkt_data == 16'h0042) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    check("mid_word_seen", hit, 1);
    reset = 1'b1;
    #1;
    check("mid_rst{valid,busy,eof,ovf}", {pkt_valid, busy, pkt_eof, ovf}, 0);
    check("mid_rst_words_consumed", exp_q.size(), 0);
    tick();
    reset = 1'b0;
    push_pkt(1'b0, CMD_DIAL, 8'h17, 16'h0051);
    write_ch(0, 16'h0051, 4);
    wait_drain("drain_after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
